// File: rtl/arb8_rr.sv
// arb8_rr: 8-way round-robin arbiter with a bounded grant length.
// A grant is chosen in IDLE from a rotating priority pointer, held in BUSY
// until the owner releases, withdraws, enable drops or MAX_HOLD expires.
// All outputs are driven straight from flops.
module arb8_rr #(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       g,
  output logic       timeout
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Hold-counter value on which the grant is revoked.
  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [3:0] hold_q, hold_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] gnt_id_q, gnt_id_d;
  logic       g_q, g_d;
  logic       timeout_q, timeout_d;

  logic       owner_req_s;
  logic       hold_hit_s;
  logic       release_s;
  logic       enable_only_s;
  logic       timeout_cause_s;
  logic [2:0] pick_s;

  // First set request bit scanning p, p+1, ..., p+7 (mod 8).
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] idx;
    logic [2:0] res;
    logic       found;
    res   = p;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx = p + 3'(k);
      if (!found && r[idx]) begin
        res   = idx;
        found = 1'b1;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Release decode: which conditions end the current grant.
  always_comb begin
    owner_req_s     = req[gnt_id_q];
    hold_hit_s      = (hold_q == HOLD_LAST);
    release_s       = done | ~owner_req_s | ~enable | hold_hit_s;
    // enable dropping on its own keeps the pointer where it is
    enable_only_s   = ~enable & ~done & owner_req_s & ~hold_hit_s;
    timeout_cause_s = hold_hit_s & ~done & owner_req_s & enable;
    pick_s          = rr_pick(req, ptr_q);
  end

  // Next-state and next-output computation for the IDLE/BUSY machine.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    g_d       = g_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && (req != 8'h00)) begin
          gnt_d    = 8'd1 << pick_s;
          gnt_id_d = pick_s;
          g_d      = 1'b1;
          hold_d   = 4'd0;
          state_d  = BUSY;
        end else begin
          gnt_d = 8'h00;
          g_d   = 1'b0;
        end
      end
      BUSY: begin
        if (hold_q == 4'd15) begin
          hold_d = 4'd15;
        end else begin
          hold_d = hold_q + 4'd1;
        end
        if (release_s) begin
          gnt_d     = 8'h00;
          g_d       = 1'b0;
          state_d   = IDLE;
          timeout_d = timeout_cause_s;
          if (enable_only_s) begin
            ptr_d = ptr_q;
          end else begin
            ptr_d = gnt_id_q + 3'd1;
          end
        end else begin
          gnt_d = gnt_q;
          g_d   = g_q;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 8'h00;
        g_d     = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears everything without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= 3'd0;
      hold_q    <= 4'd0;
      gnt_q     <= 8'h00;
      gnt_id_q  <= 3'd0;
      g_q       <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      g_q       <= g_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign g       = g_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_arb8_rr.sv
// Testbench for arb8_rr: table-driven vectors through an expected-value
// queue, plus hand-written async reset checks.
module tb_arb8_rr;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       g;
  logic       timeout;

  int n_vec;
  int n_bad;

  typedef struct {
    string      tag;
    logic       en;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] id;
    logic       g;
    logic       to;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  arb8_rr #(.MAX_HOLD(15)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .req    (req),
    .done   (done),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .g      (g),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void add(input string tag, input logic en, input logic [7:0] r,
                              input logic d, input logic [7:0] eg, input logic [2:0] eid,
                              input logic eg1, input logic eto);
    vec_t v;
    v.tag = tag; v.en = en; v.req = r; v.done = d;
    v.gnt = eg; v.id = eid; v.g = eg1; v.to = eto;
    tbl.push_back(v);
  endfunction

  task automatic check_now(input string tag, input logic [7:0] eg, input logic [2:0] eid,
                           input logic eg1, input logic eto);
    n_vec++;
    if ({gnt, gnt_id, g, timeout} !== {eg, eid, eg1, eto}) begin
      n_bad++;
      $display("FAIL %s: got gnt=%h id=%0d g=%b to=%b, want gnt=%h id=%0d g=%b to=%b",
               tag, gnt, gnt_id, g, timeout, eg, eid, eg1, eto);
    end
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    @(negedge clk);
    enable = v.en;
    req    = v.req;
    done   = v.done;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_now(e.tag, e.gnt, e.id, e.g, e.to);
  endtask

  task automatic run_tbl();
    foreach (tbl[i]) apply(tbl[i]);
    tbl.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    enable = 1'b0;
    req    = 8'h00;
    done   = 1'b0;
    #1;
    check_now("reset_state", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_vec  = 0;
    n_bad  = 0;
    rst_n  = 1'b0;
    enable = 1'b0;
    req    = 8'h00;
    done   = 1'b0;

    // Priority after reset
    do_reset();
    add("prio_g2",   1'b1, 8'h24, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0);
    add("prio_rel2", 1'b1, 8'h24, 1'b1, 8'h00, 3'd2, 1'b0, 1'b0);
    add("prio_g5",   1'b1, 8'h24, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0);
    add("prio_rel5", 1'b1, 8'h24, 1'b1, 8'h00, 3'd5, 1'b0, 1'b0);
    run_tbl();

    // Fairness and wrap; done held high also exercises done-in-IDLE
    do_reset();
    for (int i = 0; i < 9; i++) begin
      add("fair_gnt", 1'b1, 8'hFF, 1'b1, 8'd1 << (i % 8), 3'(i % 8), 1'b1, 1'b0);
      add("fair_rel", 1'b1, 8'hFF, 1'b1, 8'h00, 3'(i % 8), 1'b0, 1'b0);
    end
    run_tbl();

    // Timeout: 15 cycles of g, one timeout pulse, regrant after one IDLE cycle
    do_reset();
    for (int i = 0; i < 15; i++) begin
      add("to_hold", 1'b1, 8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);
    end
    add("to_pulse",  1'b1, 8'h01, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
    add("to_regrnt", 1'b1, 8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);
    add("to_done",   1'b1, 8'h01, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
    run_tbl();

    // Enable drop keeps the pointer
    do_reset();
    add("en_g2",     1'b1, 8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0);
    add("en_rel2",   1'b1, 8'h04, 1'b1, 8'h00, 3'd2, 1'b0, 1'b0);
    add("en_g3",     1'b1, 8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0);
    add("en_drop",   1'b0, 8'h08, 1'b0, 8'h00, 3'd3, 1'b0, 1'b0);
    add("en_idle0",  1'b0, 8'hFF, 1'b0, 8'h00, 3'd3, 1'b0, 1'b0);
    add("en_regrnt", 1'b1, 8'h88, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0);
    add("en_rel3",   1'b1, 8'h88, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0);
    add("en_g7",     1'b1, 8'h88, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0);
    run_tbl();

    // Owner withdraws; other bits changing do not disturb BUSY
    do_reset();
    add("wd_g4",    1'b1, 8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0);
    add("wd_other", 1'b1, 8'h13, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0);
    add("wd_drop",  1'b1, 8'h21, 1'b0, 8'h00, 3'd4, 1'b0, 1'b0);
    add("wd_g5",    1'b1, 8'h21, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0);
    run_tbl();

    // Async reset mid-grant, then first grant from pointer 0
    do_reset();
    add("ar_g6", 1'b1, 8'h40, 1'b0, 8'h40, 3'd6, 1'b1, 1'b0);
    run_tbl();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_now("ar_async_drop", 8'h00, 3'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_now("ar_held", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    add("ar_regrant", 1'b1, 8'hC0, 1'b0, 8'h40, 3'd6, 1'b1, 1'b0);
    add("ar_rel",     1'b1, 8'hC0, 1'b1, 8'h00, 3'd6, 1'b0, 1'b0);
    add("ar_g7",      1'b1, 8'hC0, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0);
    run_tbl();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/arb8_rr.md
ARB8_RR -- requirements
Module: arb8_rr

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 The block SHALL have parameter MAX_HOLD, default 15, meaning the maximum number of BUSY cycles one grant may last, legal range 1..15.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port enable, input, 1 bit: arbitration enable, the same role as the encoder enable.
REQ-006 The block SHALL have port req, input, 8 bits: request lines; bit i belongs to requester i.
REQ-007 The block SHALL have port done, input, 1 bit: the current owner releases the resource.
REQ-008 The block SHALL have port gnt, output, 8 bits: one-hot grant, registered.
REQ-009 The block SHALL have port gnt_id, output, 3 bits: binary index of the owner, registered.
REQ-010 The block SHALL have port g, output, 1 bit: grant valid, high exactly when gnt is non-zero.
REQ-011 The block SHALL have port timeout, output, 1 bit: one-cycle pulse when a grant is revoked by MAX_HOLD.

Function
REQ-012 The block SHALL implement two states: IDLE and BUSY.
REQ-013 The block SHALL keep a 3-bit rotating pointer ptr giving the highest-priority index; it resets to 0.
REQ-014 In IDLE, at a rising edge where enable=1 and req!=0, the block SHALL select the first set req bit scanning ptr, ptr+1, ..., ptr+7 (mod 8), register gnt/gnt_id/g for it, clear the hold counter, and enter BUSY.
REQ-015 Grant latency SHALL be one cycle: req sampled at edge N, gnt visible after edge N; no combinational path from req to gnt.
REQ-016 In IDLE with enable=0 or req=0, the block SHALL keep gnt=0, g=0 and hold gnt_id at its last value.
REQ-017 In BUSY, the block SHALL increment a 4-bit hold counter each cycle, saturating at 15.
REQ-018 In BUSY, the block SHALL release when any of the following holds: done=1; req[gnt_id]=0; enable=0; or hold counter = MAX_HOLD-1.
REQ-019 On release, at that edge the block SHALL clear gnt and g, return to IDLE, and set ptr = gnt_id+1 mod 8, with 7 wrapping to 0.
REQ-020 Exception to REQ-019: when release is caused only by enable=0, ptr SHALL be left unchanged.
REQ-021 timeout SHALL pulse for one cycle, registered with the release, only when release is caused by MAX_HOLD and done=0 and req[gnt_id]=1 and enable=1.
REQ-022 At least one IDLE cycle SHALL separate consecutive grants, so the minimum grant period is 2 cycles; back-to-back grants to a single requester are permitted only after that gap.
REQ-023 The block SHALL ignore done while in IDLE.
REQ-024 Changes to req bits other than the owner's SHALL NOT affect BUSY.
REQ-025 gnt SHALL always be one-hot or zero, and g SHALL equal |gnt in every cycle.

Reset
REQ-026 rst_n=0 SHALL immediately, without waiting for clk, force state=IDLE, ptr=0, hold counter=0, gnt=8'h00, gnt_id=3'd0, g=0, timeout=0.
REQ-027 Reset asserted mid-grant SHALL drop gnt asynchronously; after rst_n rises, the first grant SHALL use ptr=0.
REQ-028 Reset deassertion SHALL take effect at the first rising clk edge where rst_n=1.

Verification
REQ-029 Scenario, priority after reset: enable=1, req=8'h24 -> next cycle gnt=8'h04, gnt_id=2, g=1; done pulse -> gnt=0; next grant gnt=8'h20, gnt_id=5.
REQ-030 Scenario, fairness and wrap: req=8'hFF held, done pulsed every BUSY cycle -> gnt_id sequence 0,1,2,...,7,0, each grant separated by one IDLE cycle.
REQ-031 Scenario, timeout: req=8'h01 held, done=0, MAX_HOLD=15 -> g high for exactly 15 cycles, timeout=1 for one cycle, then regrant to 0 after one IDLE cycle.
REQ-032 Scenario, enable drop: owner 3 in BUSY, enable->0 -> gnt=0 next edge, ptr remains 3, no timeout pulse; enable->1 with req=8'h88 -> gnt_id=3.
REQ-033 Scenario, async reset mid-grant: rst_n=0 between clock edges while gnt=8'h40 -> gnt=0 and g=0 before the next edge; after release with req=8'hC0 -> gnt_id=6.
REQ-034 Scenario, owner withdraws: owner 4 drops req[4] while req=8'h21 -> release next edge, ptr=5, next grant gnt_id=5.
